// File: rtl/cmd_in_fifo_if.sv
// Byte-ingress and word-egress handshake between host, cmd_in_fifo and the dispatcher.
// Master drives bytes and pops; slave is the FIFO.
interface cmd_in_fifo_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        out_nempty;
    logic        out_pop;
    logic [15:0] out_data;

    modport master (
        output in_byte, in_valid, out_pop,
        input  in_ready, out_nempty, out_data
    );

    modport slave (
        input  in_byte, in_valid, out_pop,
        output in_ready, out_nempty, out_data
    );
endinterface

// File: rtl/cmd_in_fifo.sv
// Command ingress: pairs host bytes into {command, data} words, buffers them in a
// circular FIFO and hands them to the dispatcher through a registered pop port.
module cmd_in_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    cmd_in_fifo_if.slave          bus,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  byte_pending,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_HI = 1'b0,
        ST_LO = 1'b1
    } asm_state_t;

    asm_state_t state, next_state;

    logic [15:0]           mem [DEPTH];
    logic [7:0]            hi_reg;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [15:0]           out_data_r;
    logic                  full;
    logic                  in_ready_c;
    logic                  accept;
    logic                  hi_load;
    logic                  wr_en;
    logic                  pop_ok;
    logic                  pop_empty;

    assign full      = (level == FULL_LEVEL);
    assign pop_ok    = bus.out_pop && (level != '0) && !flush;
    assign pop_empty = bus.out_pop && (level == '0) && !flush;

    always_comb begin
        next_state = state;
        in_ready_c = 1'b1;
        accept     = 1'b0;
        hi_load    = 1'b0;
        wr_en      = 1'b0;
        case (state)
            ST_HI: begin
                in_ready_c = 1'b1;
                accept     = bus.in_valid;
                if (accept) begin
                    hi_load    = 1'b1;
                    next_state = ST_LO;
                end
            end
            ST_LO: begin
                in_ready_c = !full;
                accept     = bus.in_valid && !full;
                if (accept) begin
                    wr_en      = 1'b1;
                    next_state = ST_HI;
                end
            end
            default: next_state = ST_HI;
        endcase
        // flush overrides any byte accepted in the same cycle
        if (flush) begin
            hi_load    = 1'b0;
            wr_en      = 1'b0;
            next_state = ST_HI;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_HI;
            hi_reg     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            underflow  <= 1'b0;
            out_data_r <= '0;
        end else begin
            state <= next_state;
            if (hi_load)
                hi_reg <= bus.in_byte;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                underflow <= 1'b0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (pop_ok) begin
                    rd_ptr     <= rd_ptr + PTR_ONE;
                    out_data_r <= mem[rd_ptr];
                end
                if (pop_empty)
                    underflow <= 1'b1;
                case ({wr_en, pop_ok})
                    2'b10:   level <= level + LVL_ONE;
                    2'b01:   level <= level - LVL_ONE;
                    default: level <= level;
                endcase
            end
        end
    end

    // Storage carries no reset; level and pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= {hi_reg, bus.in_byte};
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_nempty = (level != '0);
    assign bus.out_data   = out_data_r;
    assign byte_pending   = (state == ST_LO);

endmodule

// File: tb/tb_cmd_in_fifo.sv
// Scoreboard bench for cmd_in_fifo at depth 4: a reference model predicts every
// output and completed words are queued, then compared as they are popped.
module tb_cmd_in_fifo;

    localparam int unsigned DL2   = 2;
    localparam int unsigned DEPTH = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           flush = 1'b0;
    logic [DL2:0]   level;
    logic           byte_pending;
    logic           underflow;

    cmd_in_fifo_if bus ();

    cmd_in_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .flush        (flush),
        .level        (level),
        .byte_pending (byte_pending),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_level;
    bit          m_lo;
    bit          m_under;
    logic [7:0]  m_hi;
    logic [15:0] m_data;
    logic [15:0] exp_q [$];
    int          dut_max_level;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0;
        m_lo    = 1'b0;
        m_under = 1'b0;
        m_hi    = '0;
        m_data  = '0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        check_eq("out_data",     bus.out_data,   m_data);
        check_eq("level",        level,          m_level);
        check_eq("out_nempty",   bus.out_nempty, m_level != 0);
        check_eq("byte_pending", byte_pending,   m_lo);
        check_eq("underflow",    underflow,      m_under);
        if (int'(level) > dut_max_level)
            dut_max_level = int'(level);
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic step(input bit v, input logic [7:0] b, input bit pop, input bit fl);
        bit rdy;
        rdy = !(m_lo && m_level == DEPTH);
        check_eq("in_ready", bus.in_ready, rdy);
        bus.in_valid = v;
        bus.in_byte  = b;
        bus.out_pop  = pop;
        flush        = fl;
        if (fl) begin
            m_level = 0;
            m_lo    = 1'b0;
            m_under = 1'b0;
            exp_q.delete();
        end else begin
            if (pop && m_level == 0)
                m_under = 1'b1;
            if (pop && m_level > 0) begin
                m_data = exp_q.pop_front();
                m_level--;
            end
            if (v && rdy) begin
                if (!m_lo) begin
                    m_hi = b;
                    m_lo = 1'b1;
                end else begin
                    exp_q.push_back({m_hi, b});
                    m_lo = 1'b0;
                    m_level++;
                end
            end
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.out_pop  = 1'b0;
        flush        = 1'b0;
        check_outputs();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_byte   = '0;
        bus.out_pop   = 1'b0;
        dut_max_level = 0;
        model_reset();

        #3;
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        check_outputs();
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(0, 8'h00, 0, 0);

        // basic ordering
        step(1, 8'h01, 0, 0);
        step(1, 8'hAA, 0, 0);
        step(1, 8'h00, 0, 0);
        step(1, 8'h55, 0, 0);
        step(0, 8'h00, 1, 0);
        check_eq("basic_w0", bus.out_data, 16'h01AA);
        step(0, 8'h00, 1, 0);
        check_eq("basic_w1", bus.out_data, 16'h0055);

        // fill and backpressure
        for (int i = 0; i < 8; i++)
            step(1, 8'h10 + 8'(i), 0, 0);
        check_eq("fill_level", level, 3'd4);
        step(1, 8'hE0, 0, 0);
        check_eq("ninth_pending", byte_pending, 1'b1);
        step(1, 8'hE1, 0, 0);
        step(1, 8'hE1, 1, 0);
        step(1, 8'hE1, 0, 0);
        check_eq("refill_level", level, 3'd4);
        for (int i = 0; i < 4; i++)
            step(0, 8'h00, 1, 0);

        // wrap-around, data = index
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(i), i > 0, 0);
            step(1, 8'(i), 0, 0);
        end
        step(0, 8'h00, 1, 0);
        check_eq("wrap_last", bus.out_data, 16'h1313);
        check_eq("level_max_ok", dut_max_level <= 4, 1'b1);

        // simultaneous push and pop at level 2
        step(1, 8'hA1, 0, 0);
        step(1, 8'hB1, 0, 0);
        step(1, 8'hA2, 0, 0);
        step(1, 8'hB2, 0, 0);
        step(1, 8'hA3, 0, 0);
        step(1, 8'hB3, 1, 0);
        check_eq("simul_level", level, 3'd2);
        check_eq("simul_head", bus.out_data, 16'hA1B1);
        for (int i = 0; i < 2; i++)
            step(0, 8'h00, 1, 0);

        // underflow, then flush with a half word pending
        step(0, 8'h00, 1, 0);
        step(1, 8'h77, 0, 0);
        step(1, 8'h88, 1, 1);

        // async reset between bytes with three words stored
        for (int i = 0; i < 7; i++)
            step(1, 8'h30 + 8'(i), 0, 0);
        reset = 1'b0;
        #2;
        model_reset();
        check_eq("arst_in_ready", bus.in_ready, 1'b1);
        check_outputs();
        @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b1;
        step(1, 8'h02, 0, 0);
        step(1, 8'h10, 0, 0);
        step(0, 8'h00, 1, 0);
        check_eq("post_rst_word", bus.out_data, 16'h0210);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmd_in_fifo.md
# cmd_in_fifo

Command ingress stage that sits directly upstream of the dispatcher. It assembles the host byte stream into 16-bit command words: the first byte is the command and the second byte is the data. It buffers those words in a circular FIFO and presents them on the pop/nempty/data interface the dispatcher consumes. The popped word is held in a register, so the dispatcher can decode it on the cycle after it pops.

## Interface
Parameters:
- DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 words (16 by default). Must be ≥ 1.

Ports:
- clock  in  1  single system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_byte  in  8  host byte
- in_valid  in  1  in_byte is valid this cycle
- in_ready  out  1  byte accepted when in_valid && in_ready
- flush  in  1  synchronous clear of FIFO contents, assembler and flags
- out_nempty  out  1  at least one word is stored
- out_pop  in  1  dispatcher pop request
- out_data  out  16  last popped word, {command, data}
- level  out  DEPTH_LOG2+1  number of stored words
- byte_pending  out  1  assembler holds a command byte and is waiting for its data byte
- underflow  out  1  sticky: out_pop was asserted while empty

## Operation
- Assembler has two states, HI and LO. Reset and flush put it in HI.
- In HI:
  - in_ready = 1.
  - An accepted byte is stored in hi_reg, and the assembler moves to LO.
- In LO:
  - in_ready = !full, where full means level == 2**DEPTH_LOG2.
  - An accepted byte writes {hi_reg, in_byte} to mem[wr_ptr], increments wr_ptr, and returns the assembler to HI.
- byte_pending = (state == LO).
- Pop: when out_pop && out_nempty, out_data <= mem[rd_ptr] and rd_ptr increments.
  - out_data holds its value until the next valid pop. It does not show ahead.
- A pop while empty changes no pointer and leaves out_data unchanged. It sets underflow.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
- level update per cycle: +1 on write only, −1 on valid pop only, unchanged when both or neither happen.
  - A write and a pop in the same cycle is legal at any level below full.
  - When full, in_ready is low, so no write can coincide with a pop.
- out_nempty = (level != 0), combinational from the level register.
- flush takes priority over everything in the same cycle:
  - wr_ptr, rd_ptr, level cleared to 0; assembler to HI; underflow cleared.
  - out_data keeps its value.
  - in_valid and out_pop are ignored that cycle.
- Reset values: out_data = 16'h0000, level = 0, out_nempty = 0, byte_pending = 0, underflow = 0, in_ready = 1.
- Reset asserted mid-operation discards everything immediately, including a half-assembled word.

## Timing
- Write latency: data byte accepted in cycle N → word stored at the edge ending N. Then level increments and out_nempty = 1 in cycle N+1.
- Pop latency: out_pop in cycle M → the new out_data is visible in cycle M+1. This matches a dispatcher that pops in its idle state and decodes in the next state.
- Throughput: one word per two input cycles on the write side, one word per cycle on the pop side.
- in_ready is combinational from state and level only, never from in_valid.
- After full deasserts because of a pop in cycle M, in_ready returns high in cycle M+1.

## Test plan
- Basic ordering: bytes 0x01,0xAA,0x00,0x55 with no pops → level = 2, out_nempty = 1, byte_pending = 0. Pop in cycle P → out_data = 0x01AA in P+1. Second pop → 0x0055, level = 0, out_nempty = 0.
- Fill and backpressure (DEPTH_LOG2 = 2): push 8 bytes → level = 4. Ninth byte is accepted into HI (byte_pending = 1); tenth byte sees in_ready = 0 and is stalled. One pop → in_ready = 1 next cycle; the tenth byte is then accepted and level returns to 4.
- Wrap-around: push and pop 20 words one after another at depth 4, with data = index → every popped word matches in sequence. level never exceeds 4.
- Simultaneous push/pop at level 2 → level stays 2, the correct head word appears on out_data, and the FIFO order is preserved.
- Underflow and flush: out_pop while empty → underflow = 1, out_data unchanged. Then one byte pushed (byte_pending = 1) followed by flush → level = 0, byte_pending = 0, underflow = 0, out_data unchanged.
- Async reset mid-stream: reset = 0 between the two bytes of a word, with 3 words stored → all outputs go to their reset values without waiting for a clock edge. After release, a new byte pair 0x02,0x10 yields 0x0210.
